alu_issue_ctrl: RTL and testbench

//   Initiator side of the ALU en/done interface: accepts ALU requests from the datapath, drives
//   ALU (en, alu_control, srcA, srcB), waits for alu_done and returns results over a valid/ready port.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// Package  : alu_pkg
// Purpose  : Shared definitions for the ALU issue controller: request opcode
//            encodings, controller FSM state encoding and default data width.
// Revision : 1.0 - initial release
//============================================================================
package alu_pkg;

   localparam int ALU_DATA_W = 32;

   // Request opcodes. 0000..1001 go to the ALU, 1010/1011 are served from
   // the local HI/LO registers, 11xx is illegal.
   localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
   localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
   localparam logic [3:0] ALU_OP_AND  = 4'b0010;
   localparam logic [3:0] ALU_OP_OR   = 4'b0011;
   localparam logic [3:0] ALU_OP_NOR  = 4'b0100;
   localparam logic [3:0] ALU_OP_SLT  = 4'b0101;
   localparam logic [3:0] ALU_OP_SLL  = 4'b0110;
   localparam logic [3:0] ALU_OP_SRL  = 4'b0111;
   localparam logic [3:0] ALU_OP_MULT = 4'b1000;
   localparam logic [3:0] ALU_OP_DIV  = 4'b1001;
   localparam logic [3:0] ALU_OP_MFHI = 4'b1010;
   localparam logic [3:0] ALU_OP_MFLO = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } alu_state_e;

   // Shifts take their amount from srcA instead of rs.
   function automatic logic op_is_shift(input logic [3:0] op);
      return (op == ALU_OP_SLL) || (op == ALU_OP_SRL);
   endfunction

   // MULT/DIV produce a HI/LO pair; the response carries LO.
   function automatic logic op_is_muldiv(input logic [3:0] op);
      return (op == ALU_OP_MULT) || (op == ALU_OP_DIV);
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
//============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Initiator side of the ALU en/done interface. Accepts one request
//            at a time, drives the ALU until alu_done (or a timeout), and
//            returns the result over a valid/ready response port. Holds the
//            architectural HI/LO registers and serves MFHI/MFLO locally.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            req_valid/ready/op/a/b/shamt - request from operand fetch
//            rsp_valid/ready/data/ovf/zero/err - response to writeback
//            alu_en/control/srcA/srcB     - ALU command
//            alu_result/hi/lo/overflow/zero/done - ALU results
// Revision : 1.0 - initial release
//============================================================================
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [4:0]        req_shamt,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_ovf,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic              alu_en,
   output logic [3:0]        alu_control,
   output logic [DATA_W-1:0] alu_srcA,
   output logic [DATA_W-1:0] alu_srcB,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] alu_hi,
   input  logic [DATA_W-1:0] alu_lo,
   input  logic              alu_overflow,
   input  logic              alu_zero,
   input  logic              alu_done
);

   localparam int                 c_CNT_W    = $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   alu_state_e          r_state,   w_state_nxt;
   logic [3:0]          r_control, w_control_nxt;
   logic [DATA_W-1:0]   r_srca,    w_srca_nxt;
   logic [DATA_W-1:0]   r_srcb,    w_srcb_nxt;
   logic [DATA_W-1:0]   r_hi,      w_hi_nxt;
   logic [DATA_W-1:0]   r_lo,      w_lo_nxt;
   logic [DATA_W-1:0]   r_rdata,   w_rdata_nxt;
   logic                r_rovf,    w_rovf_nxt;
   logic                r_rzero,   w_rzero_nxt;
   logic                r_rerr,    w_rerr_nxt;
   logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_control <= '0;
         r_srca    <= '0;
         r_srcb    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_rdata   <= '0;
         r_rovf    <= 1'b0;
         r_rzero   <= 1'b0;
         r_rerr    <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_control <= w_control_nxt;
         r_srca    <= w_srca_nxt;
         r_srcb    <= w_srcb_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_rdata   <= w_rdata_nxt;
         r_rovf    <= w_rovf_nxt;
         r_rzero   <= w_rzero_nxt;
         r_rerr    <= w_rerr_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_control_nxt = r_control;
      w_srca_nxt    = r_srca;
      w_srcb_nxt    = r_srcb;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_rdata_nxt   = r_rdata;
      w_rovf_nxt    = r_rovf;
      w_rzero_nxt   = r_rzero;
      w_rerr_nxt    = r_rerr;
      w_cnt_nxt     = r_cnt;

      unique case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_rovf_nxt = 1'b0;
               w_rerr_nxt = 1'b0;
               if (req_op == ALU_OP_MFHI || req_op == ALU_OP_MFLO) begin
                  w_rdata_nxt = (req_op == ALU_OP_MFHI) ? r_hi : r_lo;
                  w_rzero_nxt = (req_op == ALU_OP_MFHI) ? (r_hi == '0) : (r_lo == '0);
                  w_state_nxt = ST_RESP;
               end else if (req_op[3:2] == 2'b11 ||
                            (req_op == ALU_OP_DIV && req_b == '0)) begin
                  // Rejected without touching the ALU.
                  w_rdata_nxt = '0;
                  w_rzero_nxt = 1'b1;
                  w_rerr_nxt  = 1'b1;
                  w_state_nxt = ST_RESP;
               end else begin
                  w_control_nxt = req_op;
                  w_srca_nxt    = op_is_shift(req_op) ?
                                  {{(DATA_W-5){1'b0}}, req_shamt} : req_a;
                  w_srcb_nxt    = req_b;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            // alu_done is checked before the timeout so a completion on the
            // last allowed cycle is still taken as a result.
            if (alu_done) begin
               w_rdata_nxt = op_is_muldiv(r_control) ? alu_lo : alu_result;
               w_rzero_nxt = alu_zero;
               w_rovf_nxt  = (r_control == ALU_OP_ADD || r_control == ALU_OP_SUB) ?
                             alu_overflow : 1'b0;
               w_rerr_nxt  = 1'b0;
               if (op_is_muldiv(r_control)) begin
                  w_hi_nxt = alu_hi;
                  w_lo_nxt = alu_lo;
               end
               w_state_nxt = ST_RESP;
            end else if (r_cnt == c_CNT_LAST) begin
               w_rdata_nxt = '0;
               w_rzero_nxt = 1'b1;
               w_rovf_nxt  = 1'b0;
               w_rerr_nxt  = 1'b1;
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // alu_en follows BUSY directly, so the async reset drops it immediately and
   // the RESP state always leaves at least one idle cycle between two ops.
   assign req_ready   = (r_state == ST_IDLE);
   assign rsp_valid   = (r_state == ST_RESP);
   assign alu_en      = (r_state == ST_BUSY);
   assign alu_control = r_control;
   assign alu_srcA    = r_srca;
   assign alu_srcB    = r_srcb;
   assign rsp_data    = r_rdata;
   assign rsp_ovf     = r_rovf;
   assign rsp_zero    = r_rzero;
   assign rsp_err     = r_rerr;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Bench for alu_issue_ctrl. A behavioural ALU with programmable
//            done delay answers the controller; a reference model computes
//            each expected response from the operation rules and queues it,
//            and a monitor compares responses as they are handed off.
// Revision : 1.0 - initial release
//============================================================================
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int TO = 16;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_op = '0;
   logic [DW-1:0] req_a = '0, req_b = '0;
   logic [4:0]    req_shamt = '0;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_ovf, rsp_zero, rsp_err;
   logic          alu_en;
   logic [3:0]    alu_control;
   logic [DW-1:0] alu_srcA, alu_srcB;
   logic [DW-1:0] alu_result, alu_hi, alu_lo;
   logic          alu_overflow, alu_zero, alu_done;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_en(alu_en), .alu_control(alu_control),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
      .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_done(alu_done)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural ALU ----------------
   int     done_delay = 1;   // 0 = never completes
   int     busy_cnt = 0;
   logic   stray = 1'b0;     // done pulses while not enabled must be ignored
   logic   junk = 1'b0;      // garbage on outputs the controller must not use
   longint m_sa, m_sb, m_p, m_q, m_r;

   always @(posedge clk) begin
      busy_cnt <= alu_en ? busy_cnt + 1 : 0;
      stray    <= ($urandom_range(0, 3) == 0);
      junk     <= 1'($urandom);
   end

   always_comb begin
      m_sa = longint'($signed(alu_srcA));
      m_sb = longint'($signed(alu_srcB));
      m_p = m_sa * m_sb;
      m_q = 0;
      m_r = 0;
      if (m_sb != 0) begin
         m_q = m_sa / m_sb;
         m_r = m_sa % m_sb;
      end
      alu_hi = ~alu_srcA;
      alu_lo = ~alu_srcB;
      alu_overflow = junk;
      case (alu_control)
         4'd0: begin
            alu_result = alu_srcA + alu_srcB;
            alu_overflow = (alu_srcA[31] == alu_srcB[31]) && (alu_result[31] != alu_srcA[31]);
         end
         4'd1: begin
            alu_result = alu_srcA - alu_srcB;
            alu_overflow = (alu_srcA[31] != alu_srcB[31]) && (alu_result[31] != alu_srcA[31]);
         end
         4'd2: alu_result = alu_srcA & alu_srcB;
         4'd3: alu_result = alu_srcA | alu_srcB;
         4'd4: alu_result = ~(alu_srcA | alu_srcB);
         4'd5: alu_result = {31'b0, ($signed(alu_srcA) < $signed(alu_srcB))};
         4'd6: alu_result = alu_srcB << alu_srcA[4:0];
         4'd7: alu_result = alu_srcB >> alu_srcA[4:0];
         4'd8: begin
            alu_hi = m_p[63:32];
            alu_lo = m_p[31:0];
            alu_result = ~alu_lo;
         end
         4'd9: begin
            alu_hi = m_r[31:0];
            alu_lo = m_q[31:0];
            alu_result = ~alu_lo;
         end
         default: alu_result = 32'hdead_beef;
      endcase
      alu_zero = (alu_control == 4'd8 || alu_control == 4'd9) ? (alu_lo == '0) : (alu_result == '0);
      alu_done = alu_en ? (done_delay != 0 && busy_cnt + 1 >= done_delay) : stray;
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] data;
      logic        zero;
      logic        ovf;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_hi = '0;
   logic [31:0] ref_lo = '0;

   function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, b,
                                      input logic [4:0] sh, input int dly);
      exp_t   e;
      longint sa, sb2, r, q;
      e = '0;
      sa = longint'($signed(a));
      sb2 = longint'($signed(b));
      if (op == 4'd10) e.data = ref_hi;
      else if (op == 4'd11) e.data = ref_lo;
      else if (op >= 4'd12 || (op == 4'd9 && b == 0) || dly == 0 || dly > TO) e.err = 1'b1;
      else begin
         case (op)
            4'd0: begin r = sa + sb2; e.ovf = (r > MAXS) || (r < MINS); e.data = r[31:0]; end
            4'd1: begin r = sa - sb2; e.ovf = (r > MAXS) || (r < MINS); e.data = r[31:0]; end
            4'd2: e.data = a & b;
            4'd3: e.data = a | b;
            4'd4: e.data = ~(a | b);
            4'd5: e.data = (sa < sb2) ? 32'd1 : 32'd0;
            4'd6: e.data = b << sh;
            4'd7: e.data = b >> sh;
            4'd8: begin r = sa * sb2; ref_hi = r[63:32]; ref_lo = r[31:0]; e.data = ref_lo; end
            default: begin
               q = sa / sb2; r = sa % sb2;
               ref_hi = r[31:0]; ref_lo = q[31:0]; e.data = ref_lo;
            end
         endcase
      end
      e.zero = (e.data == 0);
      return e;
   endfunction

   task automatic chk(input bit ok, input string name, input longint act, input longint expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- response ready driver ----------------
   int rdy_mode = 2;   // 0 random, 1 held low, 2 held high
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t        e;
      bit          hold;
      logic [34:0] prev;
      hold = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (hold) begin
            checks++;
            if (!(rsp_valid && !req_ready && {rsp_data, rsp_zero, rsp_ovf, rsp_err} == prev)) begin
               errors++;
               $display("FAIL rsp_hold: got valid=%b req_ready=%b {data,zero,ovf,err}=%h, expected valid=1 req_ready=0 %h",
                        rsp_valid, req_ready, {rsp_data, rsp_zero, rsp_ovf, rsp_err}, prev);
            end
         end
         hold = rsp_valid && !rsp_ready;
         prev = {rsp_data, rsp_zero, rsp_ovf, rsp_err};
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got data=%h err=%b, expected no response", rsp_data, rsp_err);
            end else begin
               e = sb.pop_front();
               if (rsp_data !== e.data || rsp_err !== e.err || rsp_ovf !== e.ovf ||
                   (!e.err && rsp_zero !== e.zero) || alu_en !== 1'b0) begin
                  errors++;
                  $display("FAIL rsp: got data=%h zero=%b ovf=%b err=%b alu_en=%b, expected data=%h zero=%b ovf=%b err=%b alu_en=0",
                           rsp_data, rsp_zero, rsp_ovf, rsp_err, alu_en, e.data, e.zero, e.ovf, e.err);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] op, input logic [31:0] a, b,
                        input logic [4:0] sh, input int dly, input bit wait_rsp);
      exp_t        e;
      int          n, lat, exp_lat;
      bit          alu_path;
      logic [31:0] exp_a;
      @(posedge clk);
      #1;
      done_delay = dly;
      req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 300);
      if (!req_ready) begin
         chk(0, "accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e = ref_model(op, a, b, sh, dly);
      sb.push_back(e);
      #1;
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_op = 4'($urandom); req_shamt = 5'($urandom);
      alu_path = (op <= 4'd9) && !(op == 4'd9 && b == 0);
      exp_lat = !alu_path ? 1 : ((dly == 0 || dly > TO) ? TO + 1 : dly + 1);
      exp_a = (op == 4'd6 || op == 4'd7) ? {27'b0, sh} : a;
      @(negedge clk);
      lat = 1;
      if (alu_path) begin
         chk(alu_en === 1'b1, "alu_en_issue", longint'(alu_en), 1);
         chk(alu_control === op, "alu_control", longint'(alu_control), longint'(op));
         chk(alu_srcA === exp_a && alu_srcB === b, "alu_operands",
             {alu_srcA, alu_srcB}, {exp_a, b});
      end else begin
         chk(alu_en === 1'b0, "alu_not_issued", longint'(alu_en), 0);
      end
      if (wait_rsp) begin
         while (!rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
         end
         chk(lat == exp_lat, "latency", lat, exp_lat);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(sb.size() == 0, "drain", sb.size(), 0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h7fff_ffff;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [3:0]  op;
      logic [31:0] a, b;
      int          r, dly;

      repeat (3) @(negedge clk);
      chk(req_ready === 1'b1 && rsp_valid === 1'b0 && alu_en === 1'b0, "reset_handshake",
          {req_ready, rsp_valid, alu_en}, 3'b100);
      chk(alu_control === 4'd0 && alu_srcA === '0 && alu_srcB === '0, "reset_alu_cmd",
          {alu_control, alu_srcA}, 0);
      chk(rsp_data === '0 && rsp_err === 1'b0 && rsp_ovf === 1'b0 && rsp_zero === 1'b0,
          "reset_rsp", {rsp_data, rsp_zero, rsp_ovf, rsp_err}, 0);
      rst_n = 1'b1;

      rdy_mode = 2;
      issue(ALU_OP_ADD, 15, 10, 0, 1, 1);
      issue(ALU_OP_ADD, 32'h7fff_ffff, 1, 0, 1, 1);
      issue(ALU_OP_SUB, 32'h8000_0000, 1, 0, 2, 1);
      issue(ALU_OP_SLL, 32'h55, 4, 2, 1, 1);
      issue(ALU_OP_SRL, 32'h99, 16, 2, 2, 1);
      issue(ALU_OP_MULT, 7, 3, 0, 5, 1);
      issue(ALU_OP_MFLO, 0, 0, 0, 1, 1);
      issue(ALU_OP_MFHI, 0, 0, 0, 1, 1);
      issue(ALU_OP_DIV, 20, 3, 0, 3, 1);
      issue(ALU_OP_MFHI, 0, 0, 0, 1, 1);
      issue(ALU_OP_DIV, 20, 0, 0, 1, 1);
      issue(ALU_OP_MFLO, 0, 0, 0, 1, 1);
      issue(ALU_OP_MFHI, 0, 0, 0, 1, 1);
      issue(4'b1101, 1, 2, 0, 1, 1);
      issue(ALU_OP_ADD, 1, 1, 0, 0, 1);         // never done -> timeout
      issue(ALU_OP_ADD, 2, 3, 0, TO, 1);        // done on final cycle wins
      issue(ALU_OP_MULT, 9, 9, 0, TO + 1, 1);   // done one cycle too late
      issue(ALU_OP_MFLO, 0, 0, 0, 1, 1);        // LO untouched by the timeout

      rdy_mode = 1;
      issue(ALU_OP_SUB, 5, 5, 0, 2, 1);
      repeat (5) begin
         @(negedge clk);
         chk(req_ready === 1'b0 && rsp_valid === 1'b1, "stall_ready",
             {req_ready, rsp_valid}, 2'b01);
      end
      rdy_mode = 2;
      drain();

      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 19);
         if (r < 12) op = 4'(r);
         else if (r < 14) op = 4'(12 + $urandom_range(0, 3));
         else op = 4'($urandom_range(0, 9));
         a = pick_val();
         b = pick_val();
         if (op == ALU_OP_DIV && $urandom_range(0, 4) == 0) b = 0;
         r = $urandom_range(0, 19);
         dly = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 6);
         issue(op, a, b, 5'($urandom), dly, 1);
      end
      rdy_mode = 2;
      drain();

      // Reset in the middle of a busy op.
      issue(ALU_OP_MULT, 5, 6, 0, 1, 1);
      drain();
      issue(ALU_OP_ADD, 3, 4, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk(alu_en === 1'b1, "busy_before_reset", longint'(alu_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk(alu_en === 1'b0, "reset_drops_alu_en", longint'(alu_en), 0);
      chk(req_ready === 1'b1 && rsp_valid === 1'b0, "reset_to_idle",
          {req_ready, rsp_valid}, 2'b10);
      sb.delete();
      ref_hi = '0;
      ref_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(ALU_OP_MFHI, 0, 0, 0, 1, 1);
      issue(ALU_OP_MFLO, 0, 0, 0, 1, 1);
      issue(ALU_OP_OR, 32'hf0, 32'h0f, 0, 2, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
